// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: arbitrates set/clear requests onto a gated SR latch bank with setup/pulse/hold sequencing.
// Define SR_ARB_ROUND_ROBIN_EN for rotating-pointer arbitration; otherwise fixed lowest-index priority.
module sr_flag_arbiter #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = 4
) (
    input  logic                 C,
    input  logic                 nR,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 err,
    output logic                 busy,
    output logic [NFLAGS-1:0]    S_bus,
    output logic [NFLAGS-1:0]    R_bus,
    output logic [NFLAGS-1:0]    G_bus
);
    localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
    state_t state_q, state_d;
    logic [WW-1:0] w_q, w_d, win;
    logic [IDXW-1:0] idx_q, idx_d;
    logic op_q, op_d, arm_q, arm_d, found;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic err_q, err_d, busy_q, busy_d;
    logic [NFLAGS-1:0] s_q, s_d, r_q, r_d, g_q, g_d, oh;
`ifdef SR_ARB_ROUND_ROBIN_EN
    logic [WW-1:0] ptr_q, ptr_d;
    always_comb begin
        found = 1'b0;
        win = '0;
        for (int i = 0; i < NREQ; i++)
            if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                win = WW'((int'(ptr_q) + i) % NREQ);
            end
    end
    // pointer advances past the winner as the transaction enters HOLD
    assign ptr_d = (state_d == HOLD && state_q != HOLD)
                 ? ((w_d == WW'(NREQ - 1)) ? '0 : w_d + 1'b1) : ptr_q;
    always_ff @(posedge C or negedge nR)
        if (!nR) ptr_q <= '0;
        else ptr_q <= ptr_d;
`else
    always_comb begin
        found = 1'b0;
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i]) begin
                found = 1'b1;
                win = WW'(i);
            end
    end
`endif
    always_comb begin
        state_d = state_q;
        w_d = w_q;
        op_d = op_q;
        idx_d = idx_q;
        arm_d = arm_q;
        case (state_q)
            IDLE: if (found) begin
                w_d = win;
                op_d = op[win];
                idx_d = idx[win*IDXW +: IDXW];
                arm_d = 32'(idx_d) >= NFLAGS;
                state_d = arm_d ? HOLD : SETUP;
            end
            SETUP: state_d = PULSE;
            PULSE: state_d = HOLD;
            default: state_d = IDLE;
        endcase
        // outputs are derived from the state being entered so they register in step with it
        oh = (state_d != IDLE && !arm_d) ? NFLAGS'(1) << idx_d : '0;
        s_d = op_d ? oh : '0;
        r_d = op_d ? '0 : oh;
        g_d = (state_d == PULSE) ? oh : '0;
        gnt_d = (state_d == HOLD) ? NREQ'(1) << w_d : '0;
        err_d = state_d == HOLD && arm_d;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge C or negedge nR)
        if (!nR) begin
            state_q <= IDLE;
            w_q <= '0;
            op_q <= 1'b0;
            idx_q <= '0;
            arm_q <= 1'b0;
            s_q <= '0;
            r_q <= '0;
            g_q <= '0;
            gnt_q <= '0;
            err_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q <= w_d;
            op_q <= op_d;
            idx_q <= idx_d;
            arm_q <= arm_d;
            s_q <= s_d;
            r_q <= r_d;
            g_q <= g_d;
            gnt_q <= gnt_d;
            err_q <= err_d;
            busy_q <= busy_d;
        end
    assign S_bus = s_q;
    assign R_bus = r_q;
    assign G_bus = g_q;
    assign gnt = gnt_q;
    assign err = err_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: directed bench with a transaction-schedule model of sr_flag_arbiter.
module tb_sr_flag_arbiter;
    localparam int NREQ = 4, NFLAGS = 8, IDXW = 4;
    logic C = 1'b0, nR = 1'b1;
    logic [NREQ-1:0] req = '0, op = '0;
    logic [NREQ*IDXW-1:0] idx = '0;
    logic [NREQ-1:0] gnt;
    logic err, busy;
    logic [NFLAGS-1:0] S_bus, R_bus, G_bus;
    typedef struct packed {
        logic [7:0] s, r, g;
        logic [3:0] gnt;
        logic err, busy;
    } frame_t;
    frame_t q[$];
    frame_t act, exp_f;
    int ptr = 0, m_w, n_cmp = 0, n_bad = 0, n;
    logic [3:0] ix;
    logic [7:0] oh, sv, rv;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
        .C(C), .nR(nR), .req(req), .op(op), .idx(idx), .gnt(gnt), .err(err),
        .busy(busy), .S_bus(S_bus), .R_bus(R_bus), .G_bus(G_bus));

    always #5 C = ~C;
    assign act = {S_bus, R_bus, G_bus, gnt, err, busy};

    function automatic frame_t mk(logic [7:0] s, r, g, logic [3:0] gn, logic e, b);
        return {s, r, g, gn, e, b};
    endfunction

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic wait_gnt(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (gnt == 0 && cnt < 12);
        if (gnt == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL gnt_timeout: got no gnt within %0d cycles", cnt);
        end
    endtask

    // Model: each accepted request expands into the list of per-cycle output frames it must produce
    always @(posedge C or negedge nR)
        if (!nR) begin
            q.delete();
            ptr = 0;
        end else if (q.size() > 0) void'(q.pop_front());
        else if (req != 0) begin
`ifdef SR_ARB_ROUND_ROBIN_EN
            for (int k = NREQ - 1; k >= 0; k--) if (req[(ptr + k) % NREQ]) m_w = (ptr + k) % NREQ;
`else
            for (int k = NREQ - 1; k >= 0; k--) if (req[k]) m_w = k;
`endif
            ix = idx[m_w*IDXW +: IDXW];
            if (int'(ix) >= NFLAGS) q.push_back(mk(0, 0, 0, 4'(1) << m_w, 1, 1));
            else begin
                oh = 8'(1) << ix;
                sv = op[m_w] ? oh : 8'h00;
                rv = op[m_w] ? 8'h00 : oh;
                q.push_back(mk(sv, rv, 0, 0, 0, 1));
                q.push_back(mk(sv, rv, oh, 0, 0, 1));
                q.push_back(mk(sv, rv, 0, 4'(1) << m_w, 0, 1));
            end
            ptr = (m_w + 1) % NREQ;
        end

    always @(negedge C)
        if (nR) begin
            exp_f = (q.size() > 0) ? q[0] : '0;
            chk("cycle", act, exp_f);
            chk("s_and_r", S_bus & R_bus, 0);
            chk("g_onehot", $countones(G_bus) <= 1, 1);
        end

    initial begin
        #1 nR = 1'b0;
        #1 chk("reset_outs", act, 0);
        tick();
        tick();
        nR = 1'b1;
        // single set: requester 0, flag 3
        idx = 16'h0003; op = 4'b0001; req = 4'b0001;
        tick(); chk("set_setup", {S_bus, R_bus, G_bus, busy}, {8'h08, 8'h00, 8'h00, 1'b1});
        tick(); chk("set_pulse_g", G_bus, 8'h08);
        tick(); chk("set_hold", {G_bus, gnt, S_bus}, {8'h00, 4'b0001, 8'h08});
        tick(); chk("set_idle", {S_bus, gnt, busy}, 0); req = 0;
        // clear: requester 2, flag 7
        idx = 16'h0700; op = 4'b0000; req = 4'b0100;
        tick(); chk("clr_setup", {S_bus, R_bus, G_bus}, {8'h00, 8'h80, 8'h00});
        tick(); chk("clr_pulse", {R_bus, G_bus}, {8'h80, 8'h80});
        tick(); chk("clr_hold", {R_bus, G_bus, gnt}, {8'h80, 8'h00, 4'b0100});
        tick(); chk("clr_idle_r", R_bus, 0); req = 0;
        // out-of-range index 9 from requester 1
        idx = 16'h0090; op = 4'b0010; req = 4'b0010;
        tick(); chk("oor_hold", {gnt, err, busy, S_bus, R_bus, G_bus}, {4'b0010, 1'b1, 1'b1, 24'h0});
        tick(); chk("oor_idle", {gnt, err, busy}, 0); req = 0;
        // asynchronous reset landing in PULSE
        idx = 16'h0020; op = 4'b0010; req = 4'b0010;
        tick();
        tick(); chk("rst_pre_g", G_bus, 8'h04);
        #2 nR = 1'b0;
        #1 chk("rst_async", {G_bus, busy, gnt, S_bus}, 0);
        @(posedge C);
        @(posedge C);
        #1 nR = 1'b1;
        wait_gnt(n); chk("rst_regnt", {gnt, 8'(n)}, {4'b0010, 8'd3});
        req = 0;
        tick();
        nR = 1'b0;
        tick();
        nR = 1'b1;
        // four-way contention
        idx = 16'h0125; op = 4'b1010; req = 4'b1111;
        for (int j = 0; j < NREQ; j++) begin
            wait_gnt(n);
            chk("cont_gnt", gnt, 4'(1) << j);
            chk("cont_gap", n, (j == 0) ? 3 : 4);
            req[j] = 1'b0;
        end
        // requester 0 keeps asking after its grant
        req = 4'b0011;
        wait_gnt(n); chk("rr_first", gnt, 4'b0001);
        wait_gnt(n);
`ifdef SR_ARB_ROUND_ROBIN_EN
        chk("rr_second", gnt, 4'b0010);
`else
        chk("fp_second", gnt, 4'b0001);
`endif
        req = 0;
        repeat (6) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
